// File: rtl/ddr_rx_pkg.sv
// Shared types and helpers for the DDR receive deframer.
// State encodings are fixed so external debug taps read stable values.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        RECEIVE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_capture.sv
// DDR front end: delivers {b0,b1} per posedge, b0 being the earlier bit.
module ddr_capture (
    input  logic       clock,
    input  logic       resetq,
    input  logic       ddr_in,
    output logic [1:0] pair
);

    logic rise_q;
    logic fall_q;
    logic b0_q;

    ddr_dff u_ddff (
        .clock  (clock),
        .resetq (resetq),
        .d      (ddr_in),
        .q_rise (rise_q),
        .q_fall (fall_q)
    );

    // Retime the negedge sample so both bits launch from the same posedge.
    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) b0_q <= 1'b0;
        else         b0_q <= fall_q;
    end

    assign pair = {b0_q, rise_q};

endmodule

// File: rtl/ddr_dff.sv
// Dual-edge input flop: one sample per clock edge.
module ddr_dff (
    input  logic clock,
    input  logic resetq,
    input  logic d,
    output logic q_rise,
    output logic q_fall
);

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) q_rise <= 1'b0;
        else         q_rise <= d;
    end

    always_ff @(negedge clock or negedge resetq) begin
        if (!resetq) q_fall <= 1'b0;
        else         q_fall <= d;
    end

endmodule

// File: rtl/ddr_rx_deframer.sv
// DDR serial receiver: sync hunt, fixed-length framing, word FIFO.
module ddr_rx_deframer
    import ddr_rx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
    parameter int               FRAME_WORDS = 16
) (
    input  logic             clock,
    input  logic             resetq,
    input  logic             ddr_in,
    input  logic             enable,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             locked,
    output logic             overflow,
    input  logic             clear_overflow
);

    localparam int AW  = clog2(DEPTH);
    localparam int PW  = clog2(WIDTH / 2);
    localparam int WCW = clog2(FRAME_WORDS + 1);
    localparam logic [PW-1:0]  PAIR_LAST = PW'(WIDTH / 2 - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    logic [1:0]       pair;
    state_t           state;
    state_t           state_nx;
    logic [WIDTH-2:0] sr;
    logic             phase;
    logic [PW-1:0]    pcnt;
    logic [WCW-1:0]   wcnt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] skewed;
    logic [WIDTH-1:0] word;
    logic             sync_even;
    logic             sync_odd;
    logic             word_done;
    logic             last_word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    ddr_capture u_cap (
        .clock  (clock),
        .resetq (resetq),
        .ddr_in (ddr_in),
        .pair   (pair)
    );

    // sr keeps only WIDTH-1 bits of history; that covers both alignments.
    assign shifted   = {sr[WIDTH-3:0], pair};
    assign skewed    = {sr, pair[1]};
    assign word      = phase ? skewed : shifted;
    assign sync_even = (shifted == SYNC);
    assign sync_odd  = (skewed == SYNC);
    assign word_done = enable && (state == RECEIVE) && (pcnt == PAIR_LAST);
    assign last_word = (wcnt == WORD_LAST);

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && m_ready;
    assign push  = word_done && (!full || pop);
    assign drop  = word_done && full && !pop;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = HUNT;
            HUNT:    if (sync_even || sync_odd) state_nx = RECEIVE;
            RECEIVE: if (drop || (word_done && last_word)) state_nx = HUNT;
            default: state_nx = IDLE;
        endcase
        if (!enable) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) state <= IDLE;
        else         state <= state_nx;
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            sr    <= '0;
            phase <= 1'b0;
            pcnt  <= '0;
            wcnt  <= '0;
        end else if (!enable || state == IDLE) begin
            sr    <= '0;
            phase <= 1'b0;
            pcnt  <= '0;
            wcnt  <= '0;
        end else begin
            sr <= shifted[WIDTH-2:0];
            if (state == HUNT) begin
                pcnt  <= '0;
                wcnt  <= '0;
                phase <= !sync_even && sync_odd;
            end else if (word_done) begin
                pcnt <= '0;
                wcnt <= (drop || last_word) ? '0 : wcnt + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq)             overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

    always_ff @(posedge clock or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= word;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    assign m_data  = mem[rptr[AW-1:0]];
    assign m_valid = !empty;
    assign locked  = (state == RECEIVE);

endmodule

// File: tb/tb_ddr_rx_deframer.sv
// Directed bench for ddr_rx_deframer with a popped-word scoreboard.
module tb_ddr_rx_deframer;

    logic       clock = 1'b0;
    logic       resetq;
    logic       ddr_in;
    logic       enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       locked;
    logic       overflow;
    logic       clear_overflow;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sbq[$];
    logic       bitq[$];

    ddr_rx_deframer #(
        .WIDTH       (8),
        .DEPTH       (4),
        .SYNC        (8'hA5),
        .FRAME_WORDS (2)
    ) dut (
        .clock          (clock),
        .resetq         (resetq),
        .ddr_in         (ddr_in),
        .enable         (enable),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .locked         (locked),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshakes are sampled on the negedge; m_ready only moves at posedge+2.
    always @(negedge clock) begin
        if (resetq && m_valid && m_ready) begin
            total++;
            assert (sbq.size() > 0) else begin
                bad++;
                $error("FAIL pop_extra got=%0h exp=none", m_data);
            end
            if (sbq.size() > 0)
                check("pop_data", 32'(m_data), 32'(sbq.pop_front()));
        end
    end

    task automatic send_pair(input logic b0, input logic b1, input logic rdy);
        @(posedge clock);
        #2;
        ddr_in  = b0;
        m_ready = rdy;
        @(negedge clock);
        #2;
        ddr_in = b1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic [3:0] rdy);
        for (int i = 3; i >= 0; i--) send_pair(w[2*i+1], w[2*i], rdy[i]);
    endtask

    task automatic pad(input int n, input logic rdy);
        repeat (n) send_pair(1'b0, 1'b0, rdy);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic rdy);
        send_word(8'hA5, {4{rdy}});
        send_word(a, {4{rdy}});
        send_word(b, {4{rdy}});
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
    endtask

    task automatic flush_bits(input logic rdy);
        logic b0;
        logic b1;
        while (bitq.size() >= 2) begin
            b0 = bitq.pop_front();
            b1 = bitq.pop_front();
            send_pair(b0, b1, rdy);
        end
        if (bitq.size() == 1) begin
            b0 = bitq.pop_front();
            send_pair(b0, 1'b0, rdy);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) begin
            @(posedge clock);
            #2;
            m_ready = 1'b1;
        end
        m_ready = 1'b0;
        check("drain_empty", 32'(sbq.size()), 32'h0);
        @(negedge clock);
        check("drain_valid", 32'(m_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetq         = 1'b0;
        enable         = 1'b0;
        ddr_in         = 1'b0;
        m_ready        = 1'b0;
        clear_overflow = 1'b0;
        #22;
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_data", 32'(m_data), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clock);
        #2;
        resetq = 1'b1;
        @(posedge clock);
        #2;
        enable = 1'b1;
        pad(3, 1'b1);

        // sync lock and word latency, even alignment
        sbq.push_back(8'h3C);
        sbq.push_back(8'hF0);
        send_word(8'hA5, 4'hF);
        check("lock_early", 32'(locked), 32'h0);
        send_pair(1'b0, 1'b0, 1'b1);
        check("lock_pre", 32'(locked), 32'h0);
        send_pair(1'b1, 1'b1, 1'b1);
        check("lock_rise", 32'(locked), 32'h1);
        send_pair(1'b1, 1'b1, 1'b1);
        send_pair(1'b0, 1'b0, 1'b1);
        send_pair(1'b1, 1'b1, 1'b1);
        check("word_lat0", 32'(m_valid), 32'h0);
        send_pair(1'b1, 1'b1, 1'b1);
        check("word_lat1", 32'(m_valid), 32'h1);
        check("word_data", 32'(m_data), 32'h3C);
        send_pair(1'b0, 1'b0, 1'b1);
        send_pair(1'b0, 1'b0, 1'b1);
        send_pair(1'b0, 1'b0, 1'b1);
        check("lock_hold", 32'(locked), 32'h1);
        send_pair(1'b0, 1'b0, 1'b1);
        check("lock_fall", 32'(locked), 32'h0);
        pad(4, 1'b1);
        check("sync_sb", 32'(sbq.size()), 32'h0);

        // one junk bit puts the sync across a pair boundary
        sbq.push_back(8'h69);
        sbq.push_back(8'h96);
        send_bits(32'h1, 1);
        send_bits(32'hA5, 8);
        send_bits(32'h69, 8);
        send_bits(32'h96, 8);
        flush_bits(1'b1);
        pad(4, 1'b1);
        check("odd_sb", 32'(sbq.size()), 32'h0);
        check("odd_unlock", 32'(locked), 32'h0);
        pad(2, 1'b0);

        // overflow: the fifth word finds the FIFO full
        sbq.push_back(8'h11);
        sbq.push_back(8'h22);
        sbq.push_back(8'h33);
        sbq.push_back(8'h44);
        send_frame(8'h11, 8'h22, 1'b0);
        pad(6, 1'b0);
        send_frame(8'h33, 8'h44, 1'b0);
        pad(6, 1'b0);
        check("ovf_pre", 32'(overflow), 32'h0);
        check("full_head", 32'(m_data), 32'h11);
        send_frame(8'h55, 8'h66, 1'b0);
        pad(2, 1'b0);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_unlock", 32'(locked), 32'h0);
        @(posedge clock);
        #2;
        clear_overflow = 1'b1;
        @(posedge clock);
        #2;
        clear_overflow = 1'b0;
        @(negedge clock);
        check("ovf_clear", 32'(overflow), 32'h0);
        drain(40);

        // full FIFO with a pop in the same cycle as each write
        sbq.push_back(8'h12);
        sbq.push_back(8'h34);
        sbq.push_back(8'h56);
        sbq.push_back(8'h78);
        sbq.push_back(8'h9A);
        sbq.push_back(8'hBC);
        send_frame(8'h12, 8'h34, 1'b0);
        pad(6, 1'b0);
        send_frame(8'h56, 8'h78, 1'b0);
        pad(6, 1'b0);
        send_word(8'hA5, 4'h0);
        send_word(8'h9A, 4'h0);
        send_word(8'hBC, 4'b1000);
        send_pair(1'b0, 1'b0, 1'b1);
        pad(2, 1'b0);
        check("fp_noovf", 32'(overflow), 32'h0);
        check("fp_left", 32'(sbq.size()), 32'h4);
        check("fp_head", 32'(m_data), 32'h56);
        drain(40);

        // enable drop mid-word
        sbq.push_back(8'hC3);
        send_word(8'hA5, 4'h0);
        send_word(8'hC3, 4'h0);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        pad(3, 1'b0);
        check("en_unlock", 32'(locked), 32'h0);
        check("en_valid", 32'(m_valid), 32'h1);
        check("en_data", 32'(m_data), 32'hC3);
        @(posedge clock);
        #2;
        enable = 1'b1;
        pad(2, 1'b0);
        sbq.push_back(8'h5A);
        sbq.push_back(8'h0F);
        send_word(8'hA5, 4'hF);
        send_word(8'h5A, 4'hF);
        check("relock", 32'(locked), 32'h1);
        send_word(8'h0F, 4'hF);
        pad(4, 1'b1);
        check("en_sb", 32'(sbq.size()), 32'h0);
        pad(2, 1'b0);

        // asynchronous reset while locked with two words buffered
        send_frame(8'h81, 8'h42, 1'b0);
        pad(6, 1'b0);
        send_word(8'hA5, 4'h0);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b0, 1'b0, 1'b0);
        check("rst_pre_lock", 32'(locked), 32'h1);
        check("rst_pre_valid", 32'(m_valid), 32'h1);
        #1;
        resetq = 1'b0;
        #1;
        check("rst_mid_valid", 32'(m_valid), 32'h0);
        check("rst_mid_lock", 32'(locked), 32'h0);
        check("rst_mid_ovf", 32'(overflow), 32'h0);
        check("rst_mid_data", 32'(m_data), 32'h0);
        @(negedge clock);
        #2;
        resetq = 1'b1;
        pad(6, 1'b1);
        check("rst_no_stale", 32'(m_valid), 32'h0);
        check("final_sb", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_rx_deframer.md
# ddr_rx_deframer

Receives a single-wire double-data-rate serial stream and turns it into framed parallel words. It captures two bits per clock, one on each edge, using the team's dual-edge flip-flop. It hunts for a sync word, assembles fixed-length frames, and buffers the words in a small FIFO behind a valid/ready interface. It sits between an external DDR pin (after pin synchronisation) and the fabric-side consumer logic.

## Interface
Parameters:
- WIDTH, 8, word width in bits; must be even, ≥4
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- SYNC, 8'hA5, sync word (WIDTH bits)
- FRAME_WORDS, 16, data words per frame after sync; ≥1

Ports:
- clock  in  1  system clock; both edges used for capture only
- resetq  in  1  asynchronous active-low reset
- ddr_in  in  1  DDR data line, stable around both clock edges
- enable  in  1  receiver enable (posedge-sampled)
- m_data  out  WIDTH  head-of-FIFO word
- m_valid  out  1  m_data valid
- m_ready  in  1  consumer accepts word when m_valid&&m_ready at posedge
- locked  out  1  high while in RECEIVE state
- overflow  out  1  sticky: a word was dropped due to full FIFO
- clear_overflow  in  1  clears overflow at next posedge

## Operation
- Capture front end, at each posedge t, yields pair {b0,b1}:
  - b0 = ddr_in sampled at the negedge preceding t.
  - b1 = ddr_in sampled at posedge t.
  - b0 is earlier in time.
- Stream is MSB-first. The shift register takes 2 bits per cycle: sr <= {sr[WIDTH-3:0], b0, b1}.
- States:
  - IDLE (enable=0): shift register cleared; pair counter cleared.
  - HUNT: shift every cycle. When sr == SYNC after a shift, go to RECEIVE and clear the pair counter. Sync matches at either bit phase; one bit of skew resolves within one cycle.
  - RECEIVE: shift and count pairs. After WIDTH/2 pairs the word is complete and is written to the FIFO; the word counter increments. After FRAME_WORDS words, return to HUNT.
- Overflow:
  - If the FIFO is full when a word completes, the word is dropped and overflow is set.
  - The state returns to HUNT, so the frame is abandoned.
- enable falling in any state → IDLE next posedge. A partial word is discarded; FIFO contents and overflow are kept.
- enable rising → HUNT next posedge.
- FIFO:
  - Write and read in the same cycle are both honoured, even when full (read frees the slot first, so no overflow).
  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- clear_overflow and a new overflow event in the same cycle: set wins.
- Reset values: m_valid=0, m_data=0, locked=0, overflow=0, state=IDLE, FIFO empty, counters 0, capture flops 0.

## Timing
- Latency: the last bit of a word is sampled at posedge k. The word is written at posedge k+1, and m_valid is high after posedge k+1 when the FIFO was empty (one cycle).
- Capture adds no extra latency: b0 and b1 are both registered at posedge t and consumed by the shift logic at posedge t+1.
- locked rises one cycle after the final sync bit is captured. It falls at the posedge where the final frame word is written, on overflow, or when enable is deasserted.
- m_data changes only on a pop, or on a write to an empty FIFO.
- Throughput: one word per WIDTH/2 cycles. Sustained streaming needs m_ready high at least once per WIDTH/2 cycles.
- resetq is asynchronous. Assertion mid-frame clears everything immediately, including both capture edges. Deassertion must be synchronised externally to posedge.

## Structure
- Package ddr_rx_pkg holds:
  - state encodings (IDLE=2'd0, HUNT=2'd1, RECEIVE=2'd2)
  - a clog2 helper function
- Sub-module ddr_capture contains:
  - one dual-edge flip-flop instance
  - the posedge registers that produce {b0,b1}
- All negedge logic is confined to ddr_capture. The deframer FSM, counters and FIFO are posedge-only.
- FIFO is inline: register array plus pointers. There is no separate module.

## Test plan
- Reset mid-frame: resetq low while locked with 2 words buffered → m_valid=0, locked=0, overflow=0 immediately; after release, no stale words appear.
- Sync lock: enable=1, stream 0xA5 then 0x3C, 0xF0 (FRAME_WORDS=2, m_ready=1) → locked rises after the 8th sync bit. m_data=0x3C is valid 1 cycle after its last bit, then 0xF0. Then locked=0 and the FSM is back in HUNT.
- Odd-bit skew: precede the sync with one junk bit, so the sync straddles pairs → lock still occurs and data words decode correctly.
- Overflow: m_ready=0, DEPTH=4, frame of 6 words → 4 words buffered, overflow=1 on the 5th, HUNT. Then clear_overflow pulsed → overflow=0. FIFO drains exactly the first 4 words in order.
- Full with simultaneous pop: FIFO full, m_ready=1 in the cycle a word completes → no overflow; word count stays 4.
- Enable drop: enable=0 after 2 pairs of a word → IDLE, partial word lost, buffered words still readable. Re-enable → HUNT, and the next sync relocks.
